// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshake and single-port memory bus shared by
// the two requesters (port 0 = instruction fetch, port 1 = data) and the arbiter.
// slave  = arbiter side, master = requester/memory side.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wd0;
  logic [DATA_W-1:0] wd1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  req, we, addr0, addr1, wd0, wd1, mem_rd,
    output gnt, done, rd0, rd1, mem_addr, mem_wd, mem_we
  );

  modport master (
    output req, we, addr0, addr1, wd0, wd1, mem_rd,
    input  gnt, done, rd0, rd1, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (port 0)
// and data access (port 1). Each access runs IDLE -> ACC -> RSP, returning read
// data and a one-cycle done pulse in RSP.
// Optional feature macro: MEM_ARB_RR_EN
//   undefined : fixed priority, port 1 wins a tie
//   defined   : round-robin, the port not granted last wins a tie (port 0 after reset)
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t            state_r;
  logic              sel_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wd_r;
  logic [1:0]        gnt_r;
  logic [1:0]        done_r;
  logic              mem_we_r;
  logic [DATA_W-1:0] rd0_r;
  logic [DATA_W-1:0] rd1_r;
  logic              win_s;
`ifdef MEM_ARB_RR_EN
  logic              rr_pref_r;   // port preferred on the next tie
`endif

  // Select the winning port from the live request lines (only used in IDLE).
  always_comb begin
    win_s = 1'b0;
    case (bus.req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11: begin
`ifdef MEM_ARB_RR_EN
        win_s = rr_pref_r;
`else
        win_s = 1'b1;
`endif
      end
      default: win_s = 1'b0;
    endcase
  end

  // Access sequencer: latch the winner in IDLE, drive memory in ACC, pulse done in RSP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      sel_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wd_r      <= {DATA_W{1'b0}};
      gnt_r     <= 2'b00;
      done_r    <= 2'b00;
      mem_we_r  <= 1'b0;
      rd0_r     <= {DATA_W{1'b0}};
      rd1_r     <= {DATA_W{1'b0}};
`ifdef MEM_ARB_RR_EN
      rr_pref_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req != 2'b00) begin
            sel_r     <= win_s;
            we_r      <= bus.we[win_s];
            addr_r    <= win_s ? bus.addr1 : bus.addr0;
            wd_r      <= win_s ? bus.wd1 : bus.wd0;
            gnt_r     <= win_s ? 2'b10 : 2'b01;
            mem_we_r  <= bus.we[win_s];
`ifdef MEM_ARB_RR_EN
            rr_pref_r <= ~win_s;
`endif
            state_r   <= ST_ACC;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_ACC: begin
          mem_we_r <= 1'b0;
          done_r   <= gnt_r;
          if (!we_r) begin
            if (sel_r) begin
              rd1_r <= bus.mem_rd;
            end else begin
              rd0_r <= bus.mem_rd;
            end
          end else begin
            rd0_r <= rd0_r;
          end
          state_r  <= ST_RSP;
        end
        ST_RSP: begin
          done_r  <= 2'b00;
          gnt_r   <= 2'b00;
          state_r <= ST_IDLE;
        end
        default: begin
          gnt_r    <= 2'b00;
          done_r   <= 2'b00;
          mem_we_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // The latched transaction registers drive the memory directly, so address and
  // write data hold their last value outside ACC. The write enable is masked by
  // reset so a write aborted in ACC is never committed on the reset edge.
  assign bus.mem_addr = addr_r;
  assign bus.mem_wd   = wd_r;
  assign bus.mem_we   = mem_we_r & ~rst;
  assign bus.gnt      = gnt_r;
  assign bus.done     = done_r;
  assign bus.rd0      = rd0_r;
  assign bus.rd1      = rd1_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-timeline reference model (latency, arbitration rule, memory image).
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk;
  logic rst;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory seen by the DUT, and the model's own image of it
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  assign bus.mem_rd = mem[bus.mem_addr[9:2]];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          cyc;
  int          start_c;
  bit          m_port;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  bit          pref;
  logic [31:0] e_maddr;
  logic [31:0] e_mwd;
  logic [31:0] e_rd [2];
  logic [1:0]  last_done;

  // last observed outputs
  logic [1:0]  obs_gnt;
  logic [1:0]  obs_done;
  logic        obs_we;
  logic [31:0] obs_maddr;
  logic [31:0] obs_mwd;
  logic [31:0] obs_rd0;
  logic [31:0] obs_rd1;

  // random requester state
  bit          pend [2];
  bit          p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit pick(input logic [1:0] r);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
`ifdef MEM_ARB_RR_EN
    return pref;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive(input logic [1:0] r, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.req = r; bus.we = w;
    bus.addr0 = a0; bus.addr1 = a1;
    bus.wd0 = d0; bus.wd1 = d1;
  endtask

  // One clock cycle: predict, sample at negedge, compare, advance model and memory.
  task automatic step();
    int          ph;
    logic [1:0]  e_gnt;
    logic [1:0]  e_done;
    logic        e_we;
    bit          take;
    bit          w;
    ph     = cyc - start_c;
    e_gnt  = 2'b00;
    e_done = 2'b00;
    if (ph == 1 || ph == 2) e_gnt = m_port ? 2'b10 : 2'b01;
    if (ph == 2) e_done = e_gnt;
    e_we   = (ph == 1) && m_we && !rst;
    take   = (ph >= 3) && !rst && (bus.req != 2'b00);
    @(negedge clk);
    obs_gnt = bus.gnt; obs_done = bus.done; obs_we = bus.mem_we;
    obs_maddr = bus.mem_addr; obs_mwd = bus.mem_wd;
    obs_rd0 = bus.rd0; obs_rd1 = bus.rd1;
    check_val("gnt", {30'd0, obs_gnt}, {30'd0, e_gnt});
    check_val("done", {30'd0, obs_done}, {30'd0, e_done});
    check_val("mem_we", {31'd0, obs_we}, {31'd0, e_we});
    check_val("mem_addr", obs_maddr, e_maddr);
    check_val("mem_wd", obs_mwd, e_mwd);
    check_val("rd0", obs_rd0, e_rd[0]);
    check_val("rd1", obs_rd1, e_rd[1]);
    last_done = e_done;
    if (rst) begin
      start_c = cyc - 10;
      pref    = 1'b0;
      m_port  = 1'b0;
      m_we    = 1'b0;
      e_maddr = 32'd0;
      e_mwd   = 32'd0;
      e_rd[0] = 32'd0;
      e_rd[1] = 32'd0;
    end else begin
      if (ph == 1) begin
        if (m_we) ref_mem[m_addr[9:2]] = m_wd;
        else      e_rd[m_port] = ref_mem[m_addr[9:2]];
      end
      if (take) begin
        w       = pick(bus.req);
        pref    = !w;
        m_port  = w;
        m_we    = bus.we[w];
        m_addr  = w ? bus.addr1 : bus.addr0;
        m_wd    = w ? bus.wd1 : bus.wd0;
        start_c = cyc;
        e_maddr = m_addr;
        e_mwd   = m_wd;
      end
    end
    @(posedge clk);
    if (obs_we) mem[obs_maddr[9:2]] = obs_mwd;
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] old30;
    logic [1:0]  exp_tie;
    int          diffs;
    rst = 1'b1;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    cyc = 0; start_c = -10; pref = 1'b0; m_port = 1'b0; m_we = 1'b0;
    m_addr = 32'd0; m_wd = 32'd0; e_maddr = 32'd0; e_mwd = 32'd0;
    e_rd[0] = 32'd0; e_rd[1] = 32'd0; last_done = 2'b00;
    @(posedge clk); #1;

    // reset state
    step();
    rst = 1'b0;
    step();
    check_val("reset_gnt", {30'd0, obs_gnt}, 32'd0);
    check_val("reset_rd0", obs_rd0, 32'd0);

    // single read on port 0
    drive(2'b01, 2'b00, 32'h10, 32'd0, 32'd0, 32'd0);
    step();
    step(); check_val("t1_gnt_acc", {30'd0, obs_gnt}, 32'd1);
    step(); check_val("t1_done", {30'd0, obs_done}, 32'd1);
    drive(2'b00, 2'b00, 32'h10, 32'd0, 32'd0, 32'd0);
    step(); check_val("t1_rd0", obs_rd0, 32'hDEADBEEF);

    // write on port 1, then read it back through port 0
    drive(2'b10, 2'b10, 32'd0, 32'h20, 32'd0, 32'h12345678);
    step(); check_val("t2_we_idle", {31'd0, obs_we}, 32'd0);
    step(); check_val("t2_we_acc", {31'd0, obs_we}, 32'd1);
    step(); check_val("t2_we_rsp", {31'd0, obs_we}, 32'd0);
    drive(2'b01, 2'b00, 32'h20, 32'h20, 32'd0, 32'd0);
    step(); check_val("t2_rd1_kept", obs_rd1, 32'd0);
    step(); step();
    drive(2'b00, 2'b00, 32'h20, 32'h20, 32'd0, 32'd0);
    step(); check_val("t2_readback", obs_rd0, 32'h12345678);

    // tie with both requests held, starting from reset
    rst = 1'b1; step(); rst = 1'b0;
    drive(2'b11, 2'b00, 32'h10, 32'h20, 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (i % 3 == 2) begin
`ifdef MEM_ARB_RR_EN
        exp_tie = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
`else
        exp_tie = 2'b10;
`endif
        check_val("tie_done", {30'd0, obs_done}, {30'd0, exp_tie});
      end
    end
    drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(); step();

    // reset during ACC of a write: aborted, never committed
    old30 = mem[12];
    drive(2'b10, 2'b10, 32'd0, 32'h30, 32'd0, 32'hCAFEF00D);
    step();
    rst = 1'b1;
    step(); check_val("t5_we_in_rst", {31'd0, obs_we}, 32'd0);
    rst = 1'b0;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    check_val("t5_gnt", {30'd0, obs_gnt}, 32'd0);
    check_val("t5_done", {30'd0, obs_done}, 32'd0);
    step(); check_val("t5_mem_kept", mem[12], old30);

    // port 0 drops req and changes addr0 mid-access
    drive(2'b01, 2'b00, 32'h10, 32'd0, 32'd0, 32'd0);
    step();
    drive(2'b00, 2'b00, 32'h20, 32'd0, 32'd0, 32'd0);
    step();
    step(); check_val("t6_done", {30'd0, obs_done}, 32'd1);
    step(); check_val("t6_rd0", obs_rd0, 32'hDEADBEEF);

    // randomized traffic
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 32'd0; p_wd[p] = 32'd0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (last_done[p]) pend[p] = 1'b0;
        if (pend[p] && (cyc - start_c == 1) && (int'(m_port) == p) && $urandom_range(0, 7) == 0) begin
          pend[p]   = 1'b0;
          p_addr[p] = {22'd0, 5'($urandom_range(0, 31)), 5'd0};
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]   = 1'b1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
          p_wd[p]   = $urandom;
        end
      end
      drive({pend[1], pend[0]}, {p_we[1], p_we[0]}, p_addr[0], p_addr[1], p_wd[0], p_wd[1]);
      rst = ((cyc - start_c) != 2) && ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(); step(); step();

    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) diffs++;
    end
    check_val("mem_final", diffs, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
